// File: rtl/alu_pkg.sv
// Shared constants for the MIPS EXE-stage ALU: op codes, datapath width,
// shift-amount width and the barrel-shifter mode encoding.
package alu_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  localparam logic [3:0] ALU_OP_AND  = 4'b0000;
  localparam logic [3:0] ALU_OP_OR   = 4'b0001;
  localparam logic [3:0] ALU_OP_ADD  = 4'b0010;
  localparam logic [3:0] ALU_OP_XOR  = 4'b0011;
  localparam logic [3:0] ALU_OP_NOR  = 4'b0100;
  localparam logic [3:0] ALU_OP_SUB  = 4'b0110;
  localparam logic [3:0] ALU_OP_SLT  = 4'b0111;
  localparam logic [3:0] ALU_OP_SLTU = 4'b1000;
  localparam logic [3:0] ALU_OP_SLL  = 4'b1001;
  localparam logic [3:0] ALU_OP_SRL  = 4'b1010;
  localparam logic [3:0] ALU_OP_SRA  = 4'b1011;
  localparam logic [3:0] ALU_OP_LUI  = 4'b1100;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10
  } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational 32-bit barrel shifter: logical left, logical right and
// arithmetic right by a 5-bit amount. An amount of 0 passes the value through.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [31:0]        value,
  input  logic [SHAMT_W-1:0] shamt,
  input  shift_mode_e        mode,
  output logic [31:0]        shifted
);

  logic [31:0] shifted_s;

  // Select the shift direction/fill according to mode
  always_comb begin
    shifted_s = value;
    case (mode)
      SHIFT_SLL: shifted_s = value << shamt;
      SHIFT_SRL: shifted_s = value >> shamt;
      SHIFT_SRA: shifted_s = $unsigned($signed(value) >>> shamt);
      default:   shifted_s = value;
    endcase
  end

  assign shifted = shifted_s;

endmodule

// File: rtl/mips_alu.sv
// MIPS EXE-stage ALU. Twelve operations selected by alu_op; result and zero
// flag are registered (one-edge latency, one op per cycle).
// Optional feature macro: ALU_OVERFLOW_EN adds a registered signed-overflow
// output for ADD/SUB. Default build (macro undefined) has no overflow logic.
module mips_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_flag
`ifdef ALU_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] shifted_s;
  shift_mode_e      shift_mode_s;

  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  logic             zero_d;
  logic             zero_q;

  assign sum_s  = data1 + data2;
  assign diff_s = data1 - data2;

  // Map the shift op codes onto the shifter mode; non-shift ops don't care
  always_comb begin
    shift_mode_s = SHIFT_SRA;
    case (alu_op)
      ALU_OP_SLL: shift_mode_s = SHIFT_SLL;
      ALU_OP_SRL: shift_mode_s = SHIFT_SRL;
      ALU_OP_SRA: shift_mode_s = SHIFT_SRA;
      default:    shift_mode_s = SHIFT_SRA;
    endcase
  end

  // Shift amount comes from the low bits of operand A; upper bits ignored
  alu_shifter u_shifter (
    .value   (data2),
    .shamt   (data1[SHAMT_W-1:0]),
    .mode    (shift_mode_s),
    .shifted (shifted_s)
  );

  // Next-result selection; unused op codes yield zero
  always_comb begin
    result_d = {WIDTH{1'b0}};
    case (alu_op)
      ALU_OP_AND:  result_d = data1 & data2;
      ALU_OP_OR:   result_d = data1 | data2;
      ALU_OP_ADD:  result_d = sum_s;
      ALU_OP_XOR:  result_d = data1 ^ data2;
      ALU_OP_NOR:  result_d = ~(data1 | data2);
      ALU_OP_SUB:  result_d = diff_s;
      // Signed compare done directly, not via the SUB sign bit, so it stays
      // correct when the subtraction overflows.
      ALU_OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
      ALU_OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, (data1 < data2)};
      ALU_OP_SLL:  result_d = shifted_s;
      ALU_OP_SRL:  result_d = shifted_s;
      ALU_OP_SRA:  result_d = shifted_s;
      ALU_OP_LUI:  result_d = {data2[15:0], 16'h0000};
      default:     result_d = {WIDTH{1'b0}};
    endcase
  end

  assign zero_d = (result_d == {WIDTH{1'b0}});

  // Result and zero-flag registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= {WIDTH{1'b0}};
      zero_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign alu_result = result_q;
  assign zero_flag  = zero_q;

`ifdef ALU_OVERFLOW_EN
  logic overflow_d;
  logic overflow_q;

  // Signed overflow: ADD when like-signed operands give a different-signed
  // sum; SUB when unlike-signed operands give a result whose sign leaves A's
  always_comb begin
    overflow_d = 1'b0;
    case (alu_op)
      ALU_OP_ADD: overflow_d = (data1[WIDTH-1] == data2[WIDTH-1]) &&
                               (sum_s[WIDTH-1] != data1[WIDTH-1]);
      ALU_OP_SUB: overflow_d = (data1[WIDTH-1] != data2[WIDTH-1]) &&
                               (diff_s[WIDTH-1] != data1[WIDTH-1]);
      default:    overflow_d = 1'b0;
    endcase
  end

  // Overflow register, cleared by reset like the other outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: reset sequences, then a table of directed
// vectors applied on consecutive cycles, each checked one edge later.
module tb_mips_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        zero_flag;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  int n_checks;
  int n_fails;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  mips_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data1      (data1),
    .data2      (data2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .zero_flag  (zero_flag)
`ifdef ALU_OVERFLOW_EN
    ,
    .overflow   (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic z,
                         input logic ovf);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b;
    v.exp_res = res; v.exp_zero = z; v.exp_ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_op = op;
    data1  = a;
    data2  = b;
  endtask

  initial begin
    logic [31:0] prev_res;
    n_checks = 0;
    n_fails  = 0;

    add_vec("sub_eq",     4'b0110, 32'h0000_0010, 32'h0000_0010, 32'h0000_0000, 1'b1, 1'b0);
    add_vec("sub_neg",    4'b0110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0);
    add_vec("and",        4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0);
    add_vec("or",         4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0);
    add_vec("xor",        4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0);
    add_vec("nor",        4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 1'b0);
    add_vec("slt_neg",    4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    add_vec("sltu_big",   4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
    add_vec("slt_ovf",    4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0);
    add_vec("sltu_small", 4'b1000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    add_vec("sll4",       4'b1001, 32'h0000_0004, 32'h8000_0001, 32'h0000_0010, 1'b0, 1'b0);
    add_vec("srl4",       4'b1010, 32'h0000_0004, 32'h8000_0001, 32'h0800_0000, 1'b0, 1'b0);
    add_vec("sra4",       4'b1011, 32'h0000_0004, 32'h8000_0001, 32'hF800_0000, 1'b0, 1'b0);
    add_vec("sra_mask",   4'b1011, 32'h0000_0025, 32'h8000_0001, 32'hFC00_0000, 1'b0, 1'b0);
    add_vec("sll0",       4'b1001, 32'h0000_0000, 32'h8000_0001, 32'h8000_0001, 1'b0, 1'b0);
    add_vec("sll31",      4'b1001, 32'h0000_001F, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0);
    add_vec("srl31",      4'b1010, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
    add_vec("sra31",      4'b1011, 32'h0000_001F, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    add_vec("lui",        4'b1100, 32'hFFFF_FFFF, 32'h0000_1234, 32'h1234_0000, 1'b0, 1'b0);
    add_vec("op1111",     4'b1111, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
    add_vec("op0101",     4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
    add_vec("op1101",     4'b1101, 32'h1234_5678, 32'h8765_4321, 32'h0000_0000, 1'b1, 1'b0);
    add_vec("op1110",     4'b1110, 32'h1234_5678, 32'h8765_4321, 32'h0000_0000, 1'b1, 1'b0);
    add_vec("add_ovf",    4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    add_vec("add_carry",  4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
    add_vec("sub_ovf",    4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1);
    add_vec("sub_wrap",   4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Reset has priority over an ADD presented in the same cycle
    rst_n = 1'b0;
    drive(4'b0010, 32'h0000_0005, 32'h0000_0007);
    @(posedge clk); #1;
    check("reset_res", alu_result, 32'h0000_0000);
    check("reset_zero", {31'd0, zero_flag}, 32'h0000_0000);
`ifdef ALU_OVERFLOW_EN
    check("reset_ovf", {31'd0, overflow}, 32'h0000_0000);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("add_5_7", alu_result, 32'h0000_000C);
    check("add_5_7_zero", {31'd0, zero_flag}, 32'h0000_0000);

    // Table: one vector per cycle; outputs must hold until the next edge
    foreach (vecs[i]) begin
      @(negedge clk);
      prev_res = alu_result;
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      if (i > 0) check({vecs[i].name, "_hold"}, alu_result, prev_res);
      @(posedge clk); #1;
      check({vecs[i].name, "_res"}, alu_result, vecs[i].exp_res);
      check({vecs[i].name, "_zero"}, {31'd0, zero_flag}, {31'd0, vecs[i].exp_zero});
`ifdef ALU_OVERFLOW_EN
      check({vecs[i].name, "_ovf"}, {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
`endif
    end

    // Mid-run reset clears a nonzero result and zero flag despite a live op
    @(negedge clk);
    drive(4'b0001, 32'h0000_00FF, 32'h0000_0000);
    @(posedge clk); #1;
    check("pre_rst_or", alu_result, 32'h0000_00FF);
    @(negedge clk);
    rst_n = 1'b0;
    drive(4'b0110, 32'h0000_0005, 32'h0000_0005);
    @(posedge clk); #1;
    check("mid_rst_res", alu_result, 32'h0000_0000);
    check("mid_rst_zero", {31'd0, zero_flag}, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_sub", alu_result, 32'h0000_0000);
    check("post_rst_zero", {31'd0, zero_flag}, 32'h0000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
